// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg
// Shared constants and the controller state type for the instruction-cache
// line responder.
//   LINE_W   : width of one cache line / returned fetch line (bits)
//   WORD_W   : width of one backing-memory read beat (bits)
//   BEATS    : memory reads needed to refill one line
//   OFFSET_W : byte-offset bits inside a line (ignored on requests)
// ---------------------------------------------------------------------------
package icache_pkg;

    localparam int LINE_W   = 128;
    localparam int WORD_W   = 32;
    localparam int BEATS    = 4;
    localparam int OFFSET_W = 4;
    localparam int BEAT_W   = $clog2(BEATS);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MREQ,
        MWAIT,
        RESPOND
    } state_e;

endpackage

// File: rtl/icache_line_responder_if.sv
// ---------------------------------------------------------------------------
// icache_line_responder_if
// Bundles the fetch-side line protocol and the backing-memory word-read port.
//   fetch side : rd_en, pc_in, abort (to responder); dout, dout_valid, busy
//   memory side: mem_req, mem_addr (from responder); mem_gnt, mem_rdata,
//                mem_rvalid (to responder)
//   modport slave  : the responder itself
//   modport master : whatever drives requests and models memory
// ---------------------------------------------------------------------------
interface icache_line_responder_if #(
    parameter int ADDR_W = 32
);
    import icache_pkg::*;

    logic                rd_en;
    logic [ADDR_W-1:0]   pc_in;
    logic                abort;
    logic [LINE_W-1:0]   dout;
    logic                dout_valid;
    logic                busy;
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_gnt;
    logic [WORD_W-1:0]   mem_rdata;
    logic                mem_rvalid;

    modport slave (
        input  rd_en, pc_in, abort, mem_gnt, mem_rdata, mem_rvalid,
        output dout, dout_valid, busy, mem_req, mem_addr
    );

    modport master (
        output rd_en, pc_in, abort, mem_gnt, mem_rdata, mem_rvalid,
        input  dout, dout_valid, busy, mem_req, mem_addr
    );

endinterface

// File: rtl/icache_tag_data_array.sv
// ---------------------------------------------------------------------------
// icache_tag_data_array
// Direct-mapped storage: SETS entries of {valid, tag, 128-bit line}.
//   i_clk, i_rst : clock, synchronous active-high reset (clears valid bits)
//   rd_idx       : combinational read index -> rd_valid, rd_tag, rd_data
//   wr_en        : single write port, installs wr_tag/wr_data at wr_idx and
//                  marks the entry valid
// ---------------------------------------------------------------------------
module icache_tag_data_array
    import icache_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 24
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_data
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // NOTE: tag and data have no reset; the valid bit alone decides whether an
    // entry is used, so these arrays stay plain RAM without a reset network.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/icache_line_responder.sv
// ---------------------------------------------------------------------------
// icache_line_responder
// Answers line-fetch requests with a full 128-bit line from a direct-mapped
// cache; misses refill the line from memory as four sequential word reads.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : rd_en/pc_in/abort in, dout/dout_valid/busy out,
//                  mem_req/mem_addr out, mem_gnt/mem_rdata/mem_rvalid in
// ---------------------------------------------------------------------------
module icache_line_responder
    import icache_pkg::*;
#(
    parameter int SETS   = 16,
    parameter int ADDR_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    icache_line_responder_if.slave bus
);

    localparam int IDX_W   = $clog2(SETS);
    localparam int LADDR_W = ADDR_W - OFFSET_W;
    localparam int TAG_W   = LADDR_W - IDX_W;

    state_e                        state_q;
    logic [LADDR_W-1:0]            line_q;      // latched line address
    logic [BEAT_W-1:0]             beat_q;
    logic [BEATS-2:0][WORD_W-1:0]  buf_q;       // words 0..2; word 3 goes straight to the array
    logic                          cancel_q;
    logic                          busy_q;
    logic                          mem_req_q;
    logic [ADDR_W-1:0]             mem_addr_q;
    logic [LINE_W-1:0]             dout_q;
    logic                          dout_valid_q;

    logic                          arr_valid;
    logic [TAG_W-1:0]              arr_tag;
    logic [LINE_W-1:0]             arr_data;
    logic                          hit;
    logic                          last_beat;
    logic                          fill_done;

    // Byte offset within the line is irrelevant for a line fetch.
    logic unused_pc_offset;
    assign unused_pc_offset = ^bus.pc_in[OFFSET_W-1:0];

    assign hit       = arr_valid && (arr_tag == line_q[LADDR_W-1:IDX_W]);
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
    assign fill_done = (state_q == MWAIT) && bus.mem_rvalid && last_beat;

    // The line is installed on the edge that enters RESPOND, so RESPOND reads
    // the refilled line back from the array exactly like a hit.
    icache_tag_data_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .rd_idx   (line_q[IDX_W-1:0]),
        .rd_valid (arr_valid),
        .rd_tag   (arr_tag),
        .rd_data  (arr_data),
        .wr_en    (fill_done),
        .wr_idx   (line_q[IDX_W-1:0]),
        .wr_tag   (line_q[LADDR_W-1:IDX_W]),
        .wr_data  ({bus.mem_rdata, buf_q})
    );

    always_ff @(posedge i_clk) begin
        if (state_q == MWAIT && bus.mem_rvalid && !last_beat) begin
            buf_q[beat_q] <= bus.mem_rdata;
        end
    end

    // NOTE: every register here is assigned with <= so all state updates see
    // the pre-edge values, regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            line_q       <= '0;
            beat_q       <= '0;
            cancel_q     <= 1'b0;
            busy_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.rd_en && !bus.abort) begin
                        line_q  <= bus.pc_in[ADDR_W-1:OFFSET_W];
                        busy_q  <= 1'b1;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (bus.abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (hit) begin
                        state_q <= RESPOND;
                    end else begin
                        beat_q     <= '0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {line_q, BEAT_W'(0), 2'b00};
                        state_q    <= MREQ;
                    end
                end
                MREQ: begin
                    // Memory reads cannot be withdrawn: remember the abort and
                    // finish the refill anyway.
                    if (bus.abort) cancel_q <= 1'b1;
                    if (bus.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= MWAIT;
                    end
                end
                MWAIT: begin
                    if (bus.abort) cancel_q <= 1'b1;
                    if (bus.mem_rvalid) begin
                        if (last_beat) begin
                            state_q <= RESPOND;
                        end else begin
                            beat_q     <= beat_q + BEAT_W'(1);
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= {line_q, beat_q + BEAT_W'(1), 2'b00};
                            state_q    <= MREQ;
                        end
                    end
                end
                RESPOND: begin
                    dout_q       <= arr_data;
                    dout_valid_q <= !cancel_q && !bus.abort;
                    cancel_q     <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = busy_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_icache_line_responder.sv
// ---------------------------------------------------------------------------
// tb_icache_line_responder
// Directed scenarios plus a randomized request stream checked against a
// line-level cache model (valid + stored line address per set) and a memory
// image. A background memory agent grants requests after a configurable
// stall, returns data after a configurable delay, and checks that mem_addr
// holds steady while a request waits for its grant.
// ---------------------------------------------------------------------------
module tb_icache_line_responder;
    import icache_pkg::*;

    localparam int SETS   = 16;
    localparam int ADDR_W = 32;

    logic i_clk = 1'b0;
    logic i_rst;

    icache_line_responder_if #(.ADDR_W(ADDR_W)) bus ();

    icache_line_responder #(
        .SETS   (SETS),
        .ADDR_W (ADDR_W)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // memory agent knobs and record of granted addresses
    int          gnt_stall = 0;
    int          rsp_delay = 0;
    logic [31:0] issued [$];
    logic [31:0] mem_img [logic [31:0]];

    // reference cache model: which line address each set currently holds
    bit          m_valid [SETS];
    logic [31:0] m_line  [SETS];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
    endfunction

    function automatic logic [127:0] line_data(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:4], 4'h0};
        return {mem_word(b + 32'd12), mem_word(b + 32'd8), mem_word(b + 32'd4), mem_word(b)};
    endfunction

    initial begin : mem_agent
        int          stall;
        bit          pend;
        int          pend_cnt;
        logic [31:0] pend_addr;
        bit          prev_wait;
        logic [31:0] prev_addr;
        stall = 0; pend = 0; pend_cnt = 0; pend_addr = '0; prev_wait = 0; prev_addr = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(negedge i_clk);
            bus.mem_rvalid = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = mem_word(pend_addr);
                    pend = 0;
                end else begin
                    pend_cnt--;
                end
            end
            bus.mem_gnt = 1'b0;
            if (prev_wait && bus.mem_req === 1'b1) begin
                n_cmp++;
                if (bus.mem_addr !== prev_addr) begin
                    n_bad++;
                    $display("FAIL mem_addr_stable: got %h want %h", bus.mem_addr, prev_addr);
                end
            end
            prev_wait = 0;
            if (bus.mem_req === 1'b1) begin
                if (stall < gnt_stall) begin
                    stall++;
                    prev_wait = 1;
                    prev_addr = bus.mem_addr;
                end else begin
                    stall = 0;
                    bus.mem_gnt = 1'b1;
                    issued.push_back(bus.mem_addr);
                    pend = 1;
                    pend_cnt = rsp_delay;
                    pend_addr = bus.mem_addr;
                end
            end
        end
    end

    // Issues one request and watches it until busy drops. Observation j is
    // taken mid-cycle after the j-th edge following acceptance.
    task automatic drive_req(input logic [31:0] addr, input int abort_at, input bit junk,
                             output int done_at, output int valid_cnt, output int valid_at,
                             output logic [127:0] data, output logic busy0);
        issued.delete();
        done_at = -1; valid_cnt = 0; valid_at = -1; data = '0; busy0 = 1'b0;
        @(negedge i_clk);
        bus.rd_en = 1'b1; bus.pc_in = addr; bus.abort = 1'b0;
        for (int j = 0; j < 400; j++) begin
            @(negedge i_clk);
            if (j == 0) busy0 = bus.busy;
            if (bus.dout_valid === 1'b1) begin
                valid_cnt++;
                valid_at = j;
                data = bus.dout;
            end
            if (bus.busy === 1'b0) begin
                done_at = j;
                break;
            end
            bus.abort = (j == abort_at);
            bus.rd_en = junk ? 1'($urandom) : 1'b0;
            bus.pc_in = junk ? $urandom : addr;
        end
        bus.rd_en = 1'b0; bus.abort = 1'b0;
    endtask

    task automatic test_reset();
        bus.rd_en = 1'b0; bus.pc_in = '0; bus.abort = 1'b0;
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        n_cmp++; if (bus.dout !== '0) begin n_bad++; $display("FAIL reset_dout: got %h want 0", bus.dout); end
        n_cmp++; if (bus.dout_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dout_valid: got %b want 0", bus.dout_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        n_cmp++; if (bus.mem_addr !== '0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        i_rst = 1'b0;
    endtask

    task automatic test_cold_miss();
        int d, vc, va; logic [127:0] data; logic b0;
        mem_img[32'h100] = 32'h11; mem_img[32'h104] = 32'h22;
        mem_img[32'h108] = 32'h33; mem_img[32'h10C] = 32'h44;
        drive_req(32'h0000_0100, -1, 1'b0, d, vc, va, data, b0);
        n_cmp++; if (issued.size() != 4) begin n_bad++; $display("FAIL cold_beats: got %0d want 4", issued.size()); end
        for (int k = 0; k < 4 && k < issued.size(); k++) begin
            n_cmp++;
            if (issued[k] !== 32'h100 + 32'(4 * k)) begin
                n_bad++; $display("FAIL cold_mem_addr%0d: got %h want %h", k, issued[k], 32'h100 + 32'(4 * k));
            end
        end
        n_cmp++; if (vc != 1) begin n_bad++; $display("FAIL cold_valid_count: got %0d want 1", vc); end
        n_cmp++; if (va != 10) begin n_bad++; $display("FAIL cold_latency: got %0d want 10", va); end
        n_cmp++;
        if (data !== 128'h00000044_00000033_00000022_00000011) begin
            n_bad++; $display("FAIL cold_dout: got %h want %h", data, 128'h00000044_00000033_00000022_00000011);
        end
    endtask

    task automatic test_hit();
        int d, vc, va; logic [127:0] data; logic b0;
        drive_req(32'h0000_0108, -1, 1'b0, d, vc, va, data, b0);
        n_cmp++; if (issued.size() != 0) begin n_bad++; $display("FAIL hit_no_mem_req: got %0d want 0", issued.size()); end
        n_cmp++; if (b0 !== 1'b1) begin n_bad++; $display("FAIL hit_busy: got %b want 1", b0); end
        n_cmp++; if (vc != 1 || va != 2) begin n_bad++; $display("FAIL hit_latency: got %0d pulses at %0d want 1 at 2", vc, va); end
        n_cmp++;
        if (data !== 128'h00000044_00000033_00000022_00000011) begin
            n_bad++; $display("FAIL hit_dout: got %h want %h", data, 128'h00000044_00000033_00000022_00000011);
        end
    endtask

    task automatic test_conflict();
        int d, vc, va; logic [127:0] data; logic b0;
        drive_req(32'h0000_0200, -1, 1'b0, d, vc, va, data, b0);
        n_cmp++; if (issued.size() != 4 || issued[0] !== 32'h200) begin n_bad++; $display("FAIL conflict_refill: got %0d beats want 4 from 200", issued.size()); end
        n_cmp++; if (vc != 1 || va != 10) begin n_bad++; $display("FAIL conflict_latency: got %0d pulses at %0d want 1 at 10", vc, va); end
        n_cmp++; if (data !== line_data(32'h200)) begin n_bad++; $display("FAIL conflict_dout: got %h want %h", data, line_data(32'h200)); end
        drive_req(32'h0000_0100, -1, 1'b0, d, vc, va, data, b0);
        n_cmp++; if (issued.size() != 4) begin n_bad++; $display("FAIL conflict_remiss: got %0d beats want 4", issued.size()); end
        n_cmp++; if (data !== line_data(32'h100)) begin n_bad++; $display("FAIL conflict_redout: got %h want %h", data, line_data(32'h100)); end
    endtask

    task automatic test_abort_lookup();
        int d, vc, va; logic [127:0] data; logic b0;
        drive_req(32'h0000_0104, 0, 1'b0, d, vc, va, data, b0);
        n_cmp++; if (vc != 0) begin n_bad++; $display("FAIL abort_lookup_valid: got %0d want 0", vc); end
        n_cmp++; if (d != 1) begin n_bad++; $display("FAIL abort_lookup_busy_drop: got %0d want 1", d); end
        n_cmp++; if (issued.size() != 0) begin n_bad++; $display("FAIL abort_lookup_mem: got %0d want 0", issued.size()); end
        // rd_en and abort together: the request is dropped
        @(negedge i_clk);
        bus.rd_en = 1'b1; bus.abort = 1'b1; bus.pc_in = 32'h0000_0100;
        @(negedge i_clk);
        bus.rd_en = 1'b0; bus.abort = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_with_rd_en: got busy %b want 0", bus.busy); end
        @(negedge i_clk);
        n_cmp++; if (bus.dout_valid !== 1'b0) begin n_bad++; $display("FAIL abort_with_rd_en_valid: got %b want 0", bus.dout_valid); end
    endtask

    task automatic test_abort_refill();
        int d, vc, va; logic [127:0] data; logic b0;
        gnt_stall = 3;
        drive_req(32'h0000_0300, 4, 1'b0, d, vc, va, data, b0);
        gnt_stall = 0;
        n_cmp++; if (issued.size() != 4) begin n_bad++; $display("FAIL abort_refill_beats: got %0d want 4", issued.size()); end
        for (int k = 0; k < 4 && k < issued.size(); k++) begin
            n_cmp++;
            if (issued[k] !== 32'h300 + 32'(4 * k)) begin
                n_bad++; $display("FAIL abort_refill_addr%0d: got %h want %h", k, issued[k], 32'h300 + 32'(4 * k));
            end
        end
        n_cmp++; if (vc != 0) begin n_bad++; $display("FAIL abort_refill_valid: got %0d want 0", vc); end
        n_cmp++; if (d != 22) begin n_bad++; $display("FAIL abort_refill_done: got %0d want 22", d); end
        drive_req(32'h0000_030C, -1, 1'b0, d, vc, va, data, b0);
        n_cmp++; if (issued.size() != 0 || va != 2) begin n_bad++; $display("FAIL abort_refill_hit: got %0d beats valid at %0d want 0 at 2", issued.size(), va); end
        n_cmp++; if (data !== line_data(32'h300)) begin n_bad++; $display("FAIL abort_refill_dout: got %h want %h", data, line_data(32'h300)); end
    endtask

    task automatic test_reset_mid_refill();
        int d, vc, va; logic [127:0] data; logic b0; bit found;
        rsp_delay = 3;
        issued.delete();
        found = 0;
        @(negedge i_clk);
        bus.rd_en = 1'b1; bus.pc_in = 32'h0000_0400;
        @(negedge i_clk);
        bus.rd_en = 1'b0;
        for (int j = 0; j < 100; j++) begin
            if (issued.size() == 3 && bus.mem_req === 1'b0) begin found = 1; break; end
            @(negedge i_clk);
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL rst_mid_reach_beat2: got %0d beats want 3", issued.size()); end
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        rsp_delay = 0;
        n_cmp++; if (bus.dout !== '0) begin n_bad++; $display("FAIL rst_mid_dout: got %h want 0", bus.dout); end
        n_cmp++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_req_busy: got %b%b want 00", bus.mem_req, bus.busy); end
        n_cmp++; if (bus.mem_addr !== '0) begin n_bad++; $display("FAIL rst_mid_mem_addr: got %h want 0", bus.mem_addr); end
        for (int j = 0; j < 6; j++) begin
            @(negedge i_clk);
            n_cmp++;
            if ({bus.busy, bus.mem_req, bus.dout_valid} !== 3'b000) begin
                n_bad++; $display("FAIL rst_mid_quiet%0d: got %b want 000", j, {bus.busy, bus.mem_req, bus.dout_valid});
            end
        end
        drive_req(32'h0000_0400, -1, 1'b0, d, vc, va, data, b0);
        n_cmp++; if (issued.size() != 4 || va != 10) begin n_bad++; $display("FAIL rst_mid_remiss: got %0d beats valid at %0d want 4 at 10", issued.size(), va); end
        n_cmp++; if (data !== line_data(32'h400)) begin n_bad++; $display("FAIL rst_mid_dout_after: got %h want %h", data, line_data(32'h400)); end
        drive_req(32'h0000_0200, -1, 1'b0, d, vc, va, data, b0);
        n_cmp++; if (issued.size() != 4) begin n_bad++; $display("FAIL rst_mid_all_invalid: got %0d beats want 4", issued.size()); end
    endtask

    task automatic test_random();
        int d, vc, va; logic [127:0] data; logic b0;
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int i = 0; i < SETS; i++) m_valid[i] = 0;
        for (int n = 0; n < 40; n++) begin
            logic [31:0] line;
            logic [31:0] addr;
            int          idx;
            int          exp_done;
            int          abort_at;
            bit          hit;
            bit          refill;
            bit          junk;
            line      = 32'($urandom_range(0, 39));
            addr      = {line[27:0], 4'($urandom_range(0, 15))};
            idx       = int'(line % SETS);
            gnt_stall = $urandom_range(0, 2);
            rsp_delay = $urandom_range(0, 2);
            junk      = 1'($urandom);
            hit       = m_valid[idx] && (m_line[idx] == line);
            exp_done  = hit ? 2 : 2 + BEATS * (2 + gnt_stall + rsp_delay);
            abort_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, exp_done - 1)) : -1;
            refill    = !hit && (abort_at != 0);
            if (abort_at == 0) exp_done = 1;
            if (refill) begin m_valid[idx] = 1; m_line[idx] = line; end
            drive_req(addr, abort_at, junk, d, vc, va, data, b0);
            n_cmp++; if (d != exp_done) begin n_bad++; $display("FAIL rnd%0d_done: got %0d want %0d", n, d, exp_done); end
            n_cmp++; if (vc != ((abort_at < 0) ? 1 : 0)) begin n_bad++; $display("FAIL rnd%0d_valid_count: got %0d want %0d", n, vc, (abort_at < 0) ? 1 : 0); end
            n_cmp++; if (issued.size() != (refill ? 4 : 0)) begin n_bad++; $display("FAIL rnd%0d_beats: got %0d want %0d", n, issued.size(), refill ? 4 : 0); end
            if (refill && issued.size() > 0) begin
                n_cmp++; if (issued[0] !== {line[27:0], 4'h0}) begin n_bad++; $display("FAIL rnd%0d_mem_addr: got %h want %h", n, issued[0], {line[27:0], 4'h0}); end
            end
            if (abort_at < 0) begin
                n_cmp++; if (data !== line_data(addr)) begin n_bad++; $display("FAIL rnd%0d_dout: got %h want %h", n, data, line_data(addr)); end
            end
        end
        gnt_stall = 0; rsp_delay = 0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_abort_lookup();
        test_abort_refill();
        test_reset_mid_refill();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
